// File: rtl/reg_write_scoreboard.sv
// Write-back decoder plus busy scoreboard. It produces a registered one-hot register-file write
// enable, tracks pending writes and flags read hazards. Optional macro: REG_ZERO_HARDWIRED_EN.
module reg_write_scoreboard #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                stall,
  output logic                addr_err
);

  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                addr_err_q, addr_err_d;

  logic wb_in_range, iss_in_range;
  logic wb_zero, iss_zero;
  logic wb_ok, iss_ok, err_now;
  logic [NUM_REGS-1:0] wb_onehot, iss_onehot;
  logic stall_a, stall_b;

  assign wb_in_range  = {1'b0, wb_addr}    < NUM_REGS_L;
  assign iss_in_range = {1'b0, issue_addr} < NUM_REGS_L;

`ifdef REG_ZERO_HARDWIRED_EN
  // Register 0 reads as constant zero, so accesses to it are dropped without raising an error.
  assign wb_zero  = (wb_addr == '0);
  assign iss_zero = (issue_addr == '0);
`else
  assign wb_zero  = 1'b0;
  assign iss_zero = 1'b0;
`endif

  assign wb_ok   = wb_valid    & wb_in_range  & ~wb_zero;
  assign iss_ok  = issue_valid & iss_in_range & ~iss_zero;
  assign err_now = (wb_valid & ~wb_in_range) | (issue_valid & ~iss_in_range);

  // Out-of-range read addresses never match a bit here, so they never stall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    wb_onehot  = '0;
    iss_onehot = '0;
    stall_a    = 1'b0;
    stall_b    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wb_onehot[i]  = wb_ok  && (wb_addr    == ADDR_W'(i));
      iss_onehot[i] = iss_ok && (issue_addr == ADDR_W'(i));
      stall_a       = stall_a | (busy_q[i] && (rd_addr_a == ADDR_W'(i)));
      stall_b       = stall_b | (busy_q[i] && (rd_addr_b == ADDR_W'(i)));
    end
  end

  // A write-back clears its bit before the issue sets one, so a new producer to the same register wins.
  always_comb begin
    wr_en_d    = wb_onehot;
    busy_d     = flush ? '0 : ((busy_q & ~wb_onehot) | iss_onehot);
    addr_err_d = addr_err_q | err_now;
  end

  // NOTE: state registers use non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q    <= '0;
      busy_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign busy_mask = busy_q;
  assign addr_err  = addr_err_q;
  assign stall     = stall_a | stall_b;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Bench for reg_write_scoreboard with directed vector tables and randomized traffic. It checks a
// 16-register instance and a 12-register instance against a reference model.
module tb_reg_write_scoreboard;

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, wb_valid, flush;
  logic [3:0] issue_addr, wb_addr, rd_addr_a, rd_addr_b;

  logic [15:0] wr16, busy16;
  logic        stall16, err16;
  logic [11:0] wr12, busy12;
  logic        stall12, err12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_write_scoreboard #(.ADDR_W(4), .NUM_REGS(16)) u_dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_en(wr16), .busy_mask(busy16), .stall(stall16), .addr_err(err16)
  );

  reg_write_scoreboard #(.ADDR_W(4), .NUM_REGS(12)) u_dut12 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_en(wr12), .busy_mask(busy12), .stall(stall12), .addr_err(err12)
  );

  // Reference model: per-instance set of pending registers, the expected write enable and the error flag.
  bit          mbusy[2][16];
  logic [15:0] mwr[2];
  bit          merr[2];

  function automatic int nregs(int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic bit usable(int k, int a);
    return (a < nregs(k)) && !(ZERO_HW && a == 0);
  endfunction

  function automatic logic [31:0] model_mask(int k);
    logic [31:0] v = '0;
    for (int i = 0; i < 16; i++) if (mbusy[k][i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit model_stall(int k);
    int a = int'(rd_addr_a);
    int b = int'(rd_addr_b);
    return ((a < nregs(k)) && mbusy[k][a]) || ((b < nregs(k)) && mbusy[k][b]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mbusy[k][i] = 1'b0;
      mwr[k]  = '0;
      merr[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    int wa = int'(wb_addr);
    int ia = int'(issue_addr);
    for (int k = 0; k < 2; k++) begin
      mwr[k] = (wb_valid && usable(k, wa)) ? (16'd1 << wa) : 16'd0;
      if ((wb_valid && wa >= nregs(k)) || (issue_valid && ia >= nregs(k))) merr[k] = 1'b1;
      if (flush) begin
        for (int i = 0; i < 16; i++) mbusy[k][i] = 1'b0;
      end else begin
        if (wb_valid && usable(k, wa)) mbusy[k][wa] = 1'b0;
        if (issue_valid && usable(k, ia)) mbusy[k][ia] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    check("m16_wr",    32'(wr16),    32'(mwr[0]));
    check("m16_busy",  32'(busy16),  model_mask(0));
    check("m16_stall", 32'(stall16), 32'(model_stall(0)));
    check("m16_err",   32'(err16),   32'(merr[0]));
    check("m12_wr",    32'(wr12),    32'(mwr[1]));
    check("m12_busy",  32'(busy12),  model_mask(1));
    check("m12_stall", 32'(stall12), 32'(model_stall(1)));
    check("m12_err",   32'(err12),   32'(merr[1]));
  endtask

  // Inputs are already stable here. Advance the model, cross the edge, then sample away from it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic drive(input logic iv, input logic [3:0] ia, input logic wv, input logic [3:0] wa,
                       input logic fl, input logic [3:0] ra, input logic [3:0] rb);
    issue_valid = iv; issue_addr = ia;
    wb_valid    = wv; wb_addr    = wa;
    flush       = fl; rd_addr_a  = ra; rd_addr_b = rb;
  endtask

  typedef struct {
    logic        iv;
    logic [3:0]  ia;
    logic        wv;
    logic [3:0]  wa;
    logic        fl;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] exp_wr;
    logic [15:0] exp_busy;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic iv, logic [3:0] ia, logic wv, logic [3:0] wa, logic fl,
                              logic [3:0] ra, logic [3:0] rb,
                              logic [15:0] ewr, logic [15:0] ebusy, logic estall);
    vec_t v;
    v.iv = iv; v.ia = ia; v.wv = wv; v.wa = wa; v.fl = fl; v.ra = ra; v.rb = rb;
    v.exp_wr = ewr; v.exp_busy = ebusy; v.exp_stall = estall;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] z1;
    z1 = ZERO_HW ? 16'h0000 : 16'h0001;

    // Decode sweep, then the drop of wb_valid.
    for (int i = 0; i < 16; i++)
      add(0, 0, 1, 4'(i), 0, 15, 15, (i == 0) ? z1 : (16'd1 << i), 16'h0, 0);
    add(0, 0, 0, 0, 0, 15, 15, 16'h0000, 16'h0000, 0);
    // Hazard raised by an issue and cleared by its write-back.
    add(1, 5, 0, 0, 0, 5, 0, 16'h0000, 16'h0020, 1);
    add(0, 0, 1, 5, 0, 5, 0, 16'h0020, 16'h0000, 0);
    // Issue and write-back in the same cycle.
    add(1, 3, 0, 0, 0, 3, 3, 16'h0000, 16'h0008, 1);
    add(1, 3, 1, 3, 0, 3, 3, 16'h0008, 16'h0008, 1);
    add(1, 2, 1, 3, 0, 2, 3, 16'h0008, 16'h0004, 1);
    // Build 0x0F00, then flush together with wb 9 and a competing issue.
    add(1, 8,  1, 2, 0, 15, 15, 16'h0004, 16'h0100, 0);
    add(1, 9,  0, 0, 0, 15, 15, 16'h0000, 16'h0300, 0);
    add(1, 10, 0, 0, 0, 15, 15, 16'h0000, 16'h0700, 0);
    add(1, 11, 0, 0, 0, 11, 15, 16'h0000, 16'h0F00, 1);
    add(1, 4,  1, 9, 1, 11, 9,  16'h0200, 16'h0000, 0);
    add(0, 0,  0, 0, 0, 15, 15, 16'h0000, 16'h0000, 0);
    // A repeat issue keeps the bit set, and one write-back clears it.
    add(1, 6, 0, 0, 0, 6, 15, 16'h0000, 16'h0040, 1);
    add(1, 6, 0, 0, 0, 15, 6, 16'h0000, 16'h0040, 1);
    add(0, 0, 1, 6, 0, 6, 15, 16'h0040, 16'h0000, 0);
    // A write-back to an idle register still writes.
    add(0, 0, 1, 7, 0, 7, 7, 16'h0080, 16'h0000, 0);
    // Register 0 behaviour depends on the option.
    add(1, 0, 0, 0, 0, 0, 15, 16'h0000, z1, z1[0]);
    add(0, 0, 1, 0, 0, 0, 15, z1, 16'h0000, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_wr",   32'(wr16),   32'h0);
    check("reset_busy", 32'(busy16), 32'h0);
    check("reset_err",  32'(err16),  32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[n]) begin
      drive(vecs[n].iv, vecs[n].ia, vecs[n].wv, vecs[n].wa, vecs[n].fl, vecs[n].ra, vecs[n].rb);
      tick();
      check($sformatf("vec%0d_wr", n),    32'(wr16),    32'(vecs[n].exp_wr));
      check($sformatf("vec%0d_busy", n),  32'(busy16),  32'(vecs[n].exp_busy));
      check($sformatf("vec%0d_stall", n), 32'(stall16), 32'(vecs[n].exp_stall));
    end
    check("err16_clear", 32'(err16), 32'h0);
    check("err12_sweep", 32'(err12), 32'h1);

    // Reset in the middle of a cycle, with busy=0x0030 and a wr_en pulse pending.
    drive(1, 4, 0, 0, 0, 15, 15);
    tick();
    drive(1, 5, 1, 1, 0, 15, 15);
    tick();
    check("pre_rst_busy", 32'(busy16), 32'h0030);
    check("pre_rst_wr",   32'(wr16),   32'h0002);
    drive(0, 0, 0, 0, 0, 15, 15);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_wr",     32'(wr16),   32'h0);
    check("mid_rst_busy",   32'(busy16), 32'h0);
    check("mid_rst_err12",  32'(err12),  32'h0);
    check("mid_rst_busy12", 32'(busy12), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // An out-of-range write-back on the 12-register instance, then a flush.
    drive(1, 3, 1, 13, 0, 3, 15);
    tick();
    check("oor_wr12",   32'(wr12),   32'h0);
    check("oor_err12",  32'(err12),  32'h1);
    check("oor_busy12", 32'(busy12), 32'h0008);
    check("oor_wr16",   32'(wr16),   32'h2000);
    drive(0, 0, 0, 0, 1, 3, 15);
    tick();
    check("flush_err12",  32'(err12),  32'h1);
    check("flush_busy12", 32'(busy12), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 19) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
